// File: rtl/vram_write_scheduler_pkg.sv
// Shared VRAM constants: bus widths and scheduler FSM encodings, used by the
// write scheduler and the GPU.
package vram_write_scheduler_pkg;

    localparam int VRAM_ADDR_W = 12;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vram_wr_fifo_m.sv
// Pending-write storage: synchronous FIFO of {address, data} entries, with a
// port that rewrites the data of the newest entry in place.
module vram_wr_fifo_m #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_tail_wr,
    input  logic [DATA_W-1:0] i_tail_data,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [ADDR_W-1:0] o_tail_addr,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic [PTR_W-1:0]  w_tail_ptr;
    logic [CNT_W-1:0]  w_count_next;

    assign w_tail_ptr  = r_wr_ptr - PTR_W'(1);
    assign o_head_addr = r_addr_mem[r_rd_ptr];
    assign o_head_data = r_data_mem[r_rd_ptr];
    assign o_tail_addr = r_addr_mem[w_tail_ptr];
    assign o_count     = r_count;
    assign o_full      = r_full;
    assign o_empty     = r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr_mem[r_wr_ptr] <= i_push_addr;
            r_data_mem[r_wr_ptr] <= i_push_data;
        end else if (i_tail_wr) begin
            r_data_mem[w_tail_ptr] <= i_tail_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

endmodule

// File: rtl/vram_write_scheduler_m.sv
// Buffers CPU writes to VRAM and commits them only in cycles the GPU is not
// fetching, coalescing back-to-back writes to the same address.
module vram_write_scheduler_m
    import vram_write_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int VRAM_ADDR_W = vram_write_scheduler_pkg::VRAM_ADDR_W
) (
    input  logic                   clk_12_5875,
    input  logic                   rst,
    input  logic                   cpu_write_strobe,
    input  logic [VRAM_ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0]      cpu_data,
    input  logic                   gpu_fetch_next,
    input  logic                   in_vblank,
    output logic [VRAM_ADDR_W-1:0] vram_address,
    output logic [DATA_W-1:0]      vram_data,
    output logic                   vram_write_enable,
    output logic                   cpu_stall,
    output logic                   fifo_empty,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    sched_state_e           r_state;
    sched_state_e           w_state_next;
    logic [VRAM_ADDR_W-1:0] r_vram_address;
    logic [DATA_W-1:0]      r_vram_data;
    logic                   r_vram_we;
    logic                   r_overflow;

    logic                   w_gpu_clear;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_coalesce;
    logic                   w_overflow_set;
    logic [VRAM_ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0]      w_head_data;
    logic [VRAM_ADDR_W-1:0] w_tail_addr;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_empty;

    assign w_gpu_clear = in_vblank | ~gpu_fetch_next;

    // A strobe hitting the newest entry rewrites it, unless that entry is the
    // one leaving for VRAM this cycle.
    assign w_coalesce = cpu_write_strobe && !w_empty && (w_tail_addr == cpu_address)
                        && !(w_pop && (w_count == CNT_W'(1)));
    assign w_push         = cpu_write_strobe && !w_coalesce && (!w_full || w_pop);
    assign w_overflow_set = cpu_write_strobe && !w_coalesce && w_full && !w_pop;

    // IDLE/WAIT look at the raw strobe so the pop decision never depends on push.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty || cpu_write_strobe) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_empty && w_gpu_clear) begin
                    w_state_next = ST_COMMIT;
                    w_pop        = 1'b1;
                end else if (w_empty && !cpu_write_strobe) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (!w_empty && w_gpu_clear) begin
                    w_state_next = ST_COMMIT;
                    w_pop        = 1'b1;
                end else if (!w_empty) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_vram_we      <= 1'b0;
            r_vram_address <= '0;
            r_vram_data    <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_vram_we <= w_pop;
            if (w_pop) begin
                r_vram_address <= w_head_addr;
                r_vram_data    <= w_head_data;
            end
            if (w_overflow_set)    r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    vram_wr_fifo_m #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (VRAM_ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk       (clk_12_5875),
        .i_rst       (rst),
        .i_push      (w_push),
        .i_push_addr (cpu_address),
        .i_push_data (cpu_data),
        .i_pop       (w_pop),
        .i_tail_wr   (w_coalesce),
        .i_tail_data (cpu_data),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_tail_addr (w_tail_addr),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign vram_address      = r_vram_address;
    assign vram_data         = r_vram_data;
    assign vram_write_enable = r_vram_we;
    assign cpu_stall         = w_full;
    assign fifo_empty        = w_empty;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_vram_write_scheduler_m.sv
// Directed bench for the VRAM write scheduler: latency, GPU blocking, fill and
// overflow, coalescing, full push-with-pop and reset during a drain.
module tb_vram_write_scheduler_m;

    localparam int AW = 12;

    logic          clk_12_5875 = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_write_strobe = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = '0;
    logic          gpu_fetch_next = 1'b0;
    logic          in_vblank = 1'b0;
    logic [AW-1:0] vram_address;
    logic [7:0]    vram_data;
    logic          vram_write_enable;
    logic          cpu_stall;
    logic          fifo_empty;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    logic [AW+7:0] exp_q[$];
    int            n_checks = 0;
    int            n_fails  = 0;

    always #5 clk_12_5875 = ~clk_12_5875;

    vram_write_scheduler_m #(
        .FIFO_DEPTH  (4),
        .VRAM_ADDR_W (AW)
    ) dut (
        .clk_12_5875       (clk_12_5875),
        .rst               (rst),
        .cpu_write_strobe  (cpu_write_strobe),
        .cpu_address       (cpu_address),
        .cpu_data          (cpu_data),
        .gpu_fetch_next    (gpu_fetch_next),
        .in_vblank         (in_vblank),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_write_enable (vram_write_enable),
        .cpu_stall         (cpu_stall),
        .fifo_empty        (fifo_empty),
        .overflow          (overflow),
        .clr_overflow      (clr_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_12_5875);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_write_strobe = 1'b1;
        cpu_address      = a;
        cpu_data         = d;
        tick();
        cpu_write_strobe = 1'b0;
    endtask

    task automatic drain(input int budget, input int exp_n);
        int            n_seen;
        logic [AW+7:0] e;
        n_seen = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (vram_write_enable) begin
                n_seen++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("commit_addr", 32'(vram_address), 32'(e[AW+7:8]));
                    check_eq("commit_data", 32'(vram_data), 32'(e[7:0]));
                end
            end
        end
        check_eq("commit_count", 32'(n_seen), 32'(exp_n));
        check_eq("queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int pulses;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_we",     32'(vram_write_enable), 32'd0);
        check_eq("rst_addr",   32'(vram_address),      32'd0);
        check_eq("rst_data",   32'(vram_data),         32'd0);
        check_eq("rst_ovf",    32'(overflow),          32'd0);
        check_eq("rst_stall",  32'(cpu_stall),         32'd0);
        check_eq("rst_empty",  32'(fifo_empty),        32'd1);

        // Single write in vblank: pulse two cycles after the strobe
        in_vblank      = 1'b1;
        gpu_fetch_next = 1'b0;
        send(12'h123, 8'hA5);
        check_eq("t1_n1_we",    32'(vram_write_enable), 32'd0);
        check_eq("t1_n1_empty", 32'(fifo_empty),        32'd0);
        tick();
        check_eq("t1_n2_we",    32'(vram_write_enable), 32'd1);
        check_eq("t1_n2_addr",  32'(vram_address),      32'h123);
        check_eq("t1_n2_data",  32'(vram_data),         32'hA5);
        tick();
        check_eq("t1_n3_we",    32'(vram_write_enable), 32'd0);
        check_eq("t1_n3_empty", 32'(fifo_empty),        32'd1);
        check_eq("t1_n3_hold",  32'(vram_address),      32'h123);

        // GPU blocking for 10 cycles, then release
        in_vblank      = 1'b0;
        gpu_fetch_next = 1'b1;
        send(12'h200, 8'h5A);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vram_write_enable) pulses++;
        end
        check_eq("t2_blocked_pulses", 32'(pulses), 32'd0);
        gpu_fetch_next = 1'b0;
        tick();
        check_eq("t2_rel_we",   32'(vram_write_enable), 32'd1);
        check_eq("t2_rel_addr", 32'(vram_address),      32'h200);
        check_eq("t2_rel_data", 32'(vram_data),         32'h5A);
        tick();
        check_eq("t2_after_we", 32'(vram_write_enable), 32'd0);
        check_eq("t2_empty",    32'(fifo_empty),        32'd1);

        // Fill to full and overflow on the fifth distinct write
        gpu_fetch_next = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(12'h300 + 12'(i), 8'h30 + 8'(i));
            if (i < 4) exp_q.push_back({12'h300 + 12'(i), 8'h30 + 8'(i)});
            if (i == 2) check_eq("t3_stall_at3", 32'(cpu_stall), 32'd0);
            if (i == 3) begin
                check_eq("t3_stall_at4", 32'(cpu_stall), 32'd1);
                check_eq("t3_ovf_at4",   32'(overflow),  32'd0);
            end
        end
        check_eq("t3_ovf_at5",   32'(overflow),  32'd1);
        check_eq("t3_stall_at5", 32'(cpu_stall), 32'd1);
        gpu_fetch_next = 1'b0;
        drain(8, 4);
        check_eq("t3_ovf_sticky", 32'(overflow),   32'd1);
        check_eq("t3_empty",      32'(fifo_empty), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check_eq("t3_ovf_clr", 32'(overflow), 32'd0);

        // Coalescing two writes to the same address
        gpu_fetch_next = 1'b1;
        send(12'h010, 8'h11);
        send(12'h010, 8'h22);
        check_eq("t4_stall", 32'(cpu_stall), 32'd0);
        exp_q.push_back({12'h010, 8'h22});
        gpu_fetch_next = 1'b0;
        drain(6, 1);

        // Full FIFO: push in the same cycle as a pop is accepted
        gpu_fetch_next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(12'h400 + 12'(i), 8'h40 + 8'(i));
            exp_q.push_back({12'h400 + 12'(i), 8'h40 + 8'(i)});
        end
        check_eq("t5_full", 32'(cpu_stall), 32'd1);
        gpu_fetch_next   = 1'b0;
        cpu_write_strobe = 1'b1;
        cpu_address      = 12'h4FF;
        cpu_data         = 8'hEE;
        exp_q.push_back({12'h4FF, 8'hEE});
        tick();
        cpu_write_strobe = 1'b0;
        check_eq("t5_we",    32'(vram_write_enable), 32'd1);
        check_eq("t5_addr",  32'(vram_address),      32'h400);
        check_eq("t5_stall", 32'(cpu_stall),         32'd1);
        check_eq("t5_ovf",   32'(overflow),          32'd0);
        void'(exp_q.pop_front());
        drain(8, 4);

        // Reset in the middle of a drain discards the pending writes
        gpu_fetch_next = 1'b1;
        for (int i = 0; i < 4; i++) send(12'h500 + 12'(i), 8'h50 + 8'(i));
        gpu_fetch_next = 1'b0;
        tick();
        check_eq("t6_first_we",   32'(vram_write_enable), 32'd1);
        check_eq("t6_first_addr", 32'(vram_address),      32'h500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_we",    32'(vram_write_enable), 32'd0);
        check_eq("t6_rst_empty", 32'(fifo_empty),        32'd1);
        check_eq("t6_rst_stall", 32'(cpu_stall),         32'd0);
        check_eq("t6_rst_addr",  32'(vram_address),      32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vram_write_enable) pulses++;
        end
        check_eq("t6_no_commits", 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vram_write_scheduler_m.md
VRAM_WRITE_SCHEDULER_M -- requirements
Module: vram_write_scheduler_m

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of pending-write slots; power of two, minimum 2.
REQ-002 SHALL have parameter VRAM_ADDR_W, default 12, giving the VRAM address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_12_5875 and rst.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk_12_5875  in  1  pixel clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_write_strobe  in  1  one-cycle pulse per CPU write to VRAM (already qualified by SELECT_vram and write_enable).
- cpu_address  in  VRAM_ADDR_W  write address, valid with the strobe.
- cpu_data  in  8  write data, valid with the strobe.
- gpu_fetch_next  in  1  GPU will read VRAM in the next cycle.
- in_vblank  in  1  GPU is in vertical blank; it makes no fetches.
- vram_address  out  VRAM_ADDR_W  commit address.
- vram_data  out  8  commit data.
- vram_write_enable  out  1  one-cycle commit pulse.
- cpu_stall  out  1  FIFO full; drives the CPU RDY low.
- fifo_empty  out  1  no pending writes.
- overflow  out  1  sticky flag: a write was dropped.
- clr_overflow  in  1  clears overflow.

Function
REQ-005 SHALL queue accepted writes in a FIFO of FIFO_DEPTH entries {address, data}, in arrival order.
REQ-006 SHALL push on cpu_write_strobe; the entry is visible at the next edge.
REQ-007 SHALL coalesce writes: if the strobe address equals the newest entry's address and that entry is not being popped this cycle, it overwrites the data of that entry in place and the count does not change.
REQ-008 SHALL use a three-state FSM (IDLE, WAIT, COMMIT) with registered outputs.
REQ-009 SHALL make these FSM transitions:
- IDLE -> WAIT when the FIFO becomes non-empty.
- WAIT -> COMMIT when the FIFO is non-empty and (in_vblank=1 or gpu_fetch_next=0).
- COMMIT -> COMMIT under the same condition while entries remain.
- COMMIT -> WAIT when blocked with entries remaining.
- COMMIT -> IDLE when the FIFO is empty.
REQ-010 SHALL, on entering or staying in COMMIT, pop the head entry and register it onto vram_address and vram_data with vram_write_enable=1 for exactly that cycle.
REQ-011 SHALL hold vram_write_enable=0 in all other cycles; vram_address and vram_data hold their last values.
REQ-012 SHALL give a minimum latency of 2 cycles from strobe to vram_write_enable (strobe at cycle N, FIFO at N+1, pulse at N+2); peak throughput is one commit per cycle.
REQ-013 SHALL never assert vram_write_enable in a cycle that followed gpu_fetch_next=1 with in_vblank=0.
REQ-014 SHALL accept a push when full if a pop occurs in the same cycle; the count is unchanged.
REQ-015 SHALL, on a push when full without a pop and without coalescing, drop the write, set overflow and leave the FIFO unchanged.
REQ-016 SHALL set cpu_stall = (count == FIFO_DEPTH) and fifo_empty = (count == 0), both registered.
REQ-017 SHALL handle overflow set and clear: clr_overflow clears the flag, and a set in the same cycle as the clear wins.
REQ-018 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; the count is kept in log2(FIFO_DEPTH)+1 bits.

Reset
REQ-019 SHALL, when rst=1, at the edge: FSM to IDLE, pointers and count to 0, vram_write_enable=0, vram_address=0, vram_data=0, overflow=0, cpu_stall=0, fifo_empty=1.
REQ-020 SHALL let reset override a push, pop or commit in the same cycle; an in-flight pulse is deasserted at that edge and pending writes are discarded.

Structure
REQ-021 SHALL place VRAM_ADDR_W, DATA_W=8 and the FSM state encodings in a shared VRAM constants package used by this block and the GPU.
REQ-022 SHALL implement the storage as one sub-module, vram_wr_fifo_m (sync FIFO with push, pop, full, empty, count and a tail-overwrite port); the FSM and coalescing logic stay in the parent.

Verification
REQ-023 SHALL cover a single write in vblank: strobe at N with addr=0x123, data=0xA5, in_vblank=1 -> vram_write_enable=1 at N+2 with 0x123/0xA5; fifo_empty=1 at N+3.
REQ-024 SHALL cover blocking: gpu_fetch_next=1, in_vblank=0 for 10 cycles after a strobe -> no pulse; a pulse follows 1 cycle after gpu_fetch_next falls.
REQ-025 SHALL cover fill and overflow: 5 distinct writes with GPU blocked (DEPTH 4) -> cpu_stall=1 after the 4th, overflow=1 after the 5th; on release, exactly 4 commits in order.
REQ-026 SHALL cover coalescing: two strobes to addr 0x010 with data 0x11 then 0x22 while blocked -> one commit, data 0x22.
REQ-027 SHALL cover full with simultaneous push and pop: FIFO full, commit cycle and strobe together -> write accepted, overflow stays 0, count stays 4.
REQ-028 SHALL cover reset mid-drain: rst=1 during COMMIT with 3 entries -> vram_write_enable=0 next cycle, fifo_empty=1, no further commits.
